uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 79 +++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, glitch rejection and break handling
module uart_rx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic sd, half_hit, bit_hit;
  assign sd = sync_q[1];
  assign half_hit = cnt_q == HALF_END;
  assign bit_hit = cnt_q == BIT_END;
  assign data_out = data_q;
  assign valid = valid_q;
  assign frame_err = ferr_q;
  assign busy = state_q != IDLE;
  // State and datapath registers; reset returns everything to idle-line values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  // Next state: sample at mid-start, then every full bit; stop bit exits at its midpoint
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = sd ? IDLE : START;
      START:   if (half_hit) state_d = sd ? IDLE : DATA;
      DATA:    if (bit_hit && bit_q == 3'd7) state_d = STOP;
      STOP:    if (bit_hit) state_d = sd ? IDLE : BRK;
      BRK:     state_d = sd ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  // Counters, shift register and output pulses
  always_comb begin
    sync_d = {sync_q[0], din};
    cnt_d = (state_q == IDLE || state_q == BRK || state_d != state_q || (state_q == DATA && bit_hit)) ? '0 : cnt_q + 1'b1;
    bit_d = state_q == DATA ? (bit_hit ? bit_q + 3'd1 : bit_q) : 3'd0;
    shift_d = shift_q;
    if (state_q == DATA && bit_hit) shift_d[bit_q] = sd;
    valid_d = state_q == STOP && bit_hit && sd;
    ferr_d = state_q == STOP && bit_hit && !sd;
    data_d = valid_d ? shift_q : data_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a byte-queue reference model
module tb_uart_rx;
  localparam int CPB = 12000000 / 115200;
  localparam int HALF = CPB / 2;
  logic clk = 1'b0, rst = 1'b0, din = 1'b1;
  logic [7:0] data_out;
  logic valid, frame_err, busy;
  int vectors = 0, errors = 0;
  int cyc = 0, t_start = 0, n_valid = 0, n_ferr = 0, lowrun = 0, maxlow = 0;
  bit b2b = 1'b0, prev_valid = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] exp_q[$];

  uart_rx dut (.clk(clk), .rst(rst), .din(din), .data_out(data_out), .valid(valid), .frame_err(frame_err), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    din = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      din = fr[i];
      if (i == 0) t_start = cyc + 1;
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send(b, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid pulse must match the next expected byte and arrive on time
  always @(negedge clk) begin
    int lat;
    if (!rst) begin
      model_data = 8'h00;
      chk("reset_outputs", 32'({data_out, valid, frame_err, busy}), 32'h0);
    end else begin
      if (valid) begin
        chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) model_data = exp_q.pop_front();
        lat = cyc - t_start;
        vectors++;
        assert (lat >= 988 && lat <= 992) else begin
          errors++;
          $error("FAIL latency observed=%0d expected=990+/-2", lat);
        end
        chk("valid_width", 32'(prev_valid), 32'd0);
        n_valid++;
      end
      if (frame_err) n_ferr++;
      chk("data_out", 32'(data_out), 32'(model_data));
      chk("valid_ferr_excl", 32'(valid & frame_err), 32'd0);
    end
    prev_valid = valid;
    if (b2b && !busy) lowrun++;
    else lowrun = 0;
    if (lowrun > maxlow) maxlow = lowrun;
  end

  initial begin
    int t0, w, dly;
    logic [7:0] rb;
    repeat (5) @(negedge clk);
    #1 chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_good(8'h00);
    send_good(8'hFF);
    settle();
    chk("two_frames_valid", n_valid, 2);
    chk("two_frames_ferr", n_ferr, 0);
    repeat (20) @(negedge clk);
    send_good(8'h05);
    b2b = 1'b1;
    send_good(8'hFF);
    send_good(8'h55);
    send_good(8'h00);
    send_good(8'hAA);
    b2b = 1'b0;
    settle();
    chk("b2b_valid", n_valid, 7);
    chk("b2b_data", 32'(data_out), 32'hAA);
    vectors++;
    assert (maxlow <= HALF + 3) else begin
      errors++;
      $error("FAIL b2b_idle_run observed=%0d expected<=%0d", maxlow, HALF + 3);
    end
    repeat (20) @(negedge clk);
    @(negedge clk);
    din = 1'b0;
    t0 = cyc + 1;
    repeat (20) @(negedge clk);
    din = 1'b1;
    chk("glitch_busy_high", 32'(busy), 32'd1);
    w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    dly = cyc - t0;
    vectors++;
    assert (!busy && dly <= HALF + 3) else begin
      errors++;
      $error("FAIL glitch_busy_drop observed=%0d expected<=%0d", dly, HALF + 3);
    end
    repeat (CPB * 2) @(negedge clk);
    settle();
    chk("glitch_valid", n_valid, 7);
    chk("glitch_ferr", n_ferr, 0);
    send(8'h3C, 1'b0);
    repeat (500) @(negedge clk);
    settle();
    chk("break_ferr", n_ferr, 1);
    chk("break_data_hold", 32'(data_out), 32'hAA);
    chk("break_busy", 32'(busy), 32'd1);
    @(negedge clk);
    din = 1'b1;
    repeat (20) @(negedge clk);
    send_good(8'h81);
    settle();
    chk("after_break_valid", n_valid, 8);
    chk("after_break_data", 32'(data_out), 32'h81);
    chk("after_break_ferr", n_ferr, 1);
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      send_good(rb);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    settle();
    chk("random_valid", n_valid, 14);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clk);
    din = 1'b0;
    repeat (51) @(negedge clk);
    #2 rst = 1'b0;
    din = 1'b1;
    #1 chk("async_reset", 32'({data_out, valid, frame_err, busy}), 32'h0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    settle();
    chk("reset_no_pulse", n_valid + n_ferr, 15);
    repeat (3) @(negedge clk);
    send_good(8'h5A);
    settle();
    chk("post_reset_valid", n_valid, 15);
    chk("post_reset_data", 32'(data_out), 32'h5A);
    chk("final_ferr", n_ferr, 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
